// File: rtl/mesh_nic_fifo.sv
// Mesh network interface: CPU-facing register port with a TX FIFO toward the
// router and an RX FIFO from the router, VC-gated injection on net_polarity.
module mesh_nic_fifo #(
  parameter int PACKET_WIDTH = 64,
  parameter int DEPTH        = 4,
  parameter int VC_BIT       = 63
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              addr,
  input  logic [PACKET_WIDTH-1:0] d_in,
  output logic [PACKET_WIDTH-1:0] d_out,
  input  logic                    nicEn,
  input  logic                    nicEnWR,
  output logic                    net_si,
  input  logic                    net_ri,
  output logic [PACKET_WIDTH-1:0] net_di,
  input  logic                    net_so,
  output logic                    net_ro,
  input  logic [PACKET_WIDTH-1:0] net_do,
  input  logic                    net_polarity
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PACKET_WIDTH-1:0] tx_mem_q [DEPTH];
  logic [PACKET_WIDTH-1:0] tx_mem_d [DEPTH];
  logic [PACKET_WIDTH-1:0] rx_mem_q [DEPTH];
  logic [PACKET_WIDTH-1:0] rx_mem_d [DEPTH];
  logic [PW-1:0]           tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [PW-1:0]           rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CW-1:0]           tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic [PACKET_WIDTH-1:0] d_out_q, d_out_d;

  logic                    tx_full, rx_empty, cpu_rd;
  logic                    tx_push, tx_pop, rx_push, rx_pop;
  logic [PACKET_WIDTH-1:0] tx_head;

  always_comb begin
    tx_full  = (tx_count_q == FULL);
    rx_empty = (rx_count_q == '0);
    tx_head  = tx_mem_q[tx_rd_ptr_q];
    net_di   = tx_head;
    // Only the head may inject; a VC mismatch stalls everything behind it.
    net_si   = (tx_count_q != '0) && net_ri && (tx_head[VC_BIT] == net_polarity);
    net_ro   = (rx_count_q < FULL);
    cpu_rd   = nicEn && !nicEnWR;
    tx_push  = nicEn && nicEnWR && (addr == 2'b10) && !tx_full;
    tx_pop   = net_si;
    rx_push  = net_so && net_ro;
    rx_pop   = cpu_rd && (addr == 2'b00) && !rx_empty;
    d_out    = d_out_q;
  end

  always_comb begin
    tx_mem_d    = tx_mem_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_count_d  = tx_count_q;
    if (tx_push) begin
      tx_mem_d[tx_wr_ptr_q] = d_in;
      tx_wr_ptr_d           = tx_wr_ptr_q + PW'(1);
    end
    if (tx_pop) begin
      tx_rd_ptr_d = tx_rd_ptr_q + PW'(1);
    end
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + CW'(1);
      2'b01:   tx_count_d = tx_count_q - CW'(1);
      default: tx_count_d = tx_count_q;
    endcase
  end

  always_comb begin
    rx_mem_d    = rx_mem_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_count_d  = rx_count_q;
    if (rx_push) begin
      rx_mem_d[rx_wr_ptr_q] = net_do;
      rx_wr_ptr_d           = rx_wr_ptr_q + PW'(1);
    end
    if (rx_pop) begin
      rx_rd_ptr_d = rx_rd_ptr_q + PW'(1);
    end
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + CW'(1);
      2'b01:   rx_count_d = rx_count_q - CW'(1);
      default: rx_count_d = rx_count_q;
    endcase
  end

  always_comb begin
    d_out_d = d_out_q;
    if (cpu_rd) begin
      case (addr)
        2'b00:   d_out_d = rx_empty ? '0 : rx_mem_q[rx_rd_ptr_q];
        2'b01:   d_out_d = PACKET_WIDTH'(!rx_empty);
        2'b10:   d_out_d = '0;
        default: d_out_d = PACKET_WIDTH'(tx_full);
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_mem_q    <= '{default: '0};
      rx_mem_q    <= '{default: '0};
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      d_out_q     <= '0;
    end else begin
      tx_mem_q    <= tx_mem_d;
      rx_mem_q    <= rx_mem_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
      d_out_q     <= d_out_d;
    end
  end

endmodule

// File: tb/tb_mesh_nic_fifo.sv
// Bench for mesh_nic_fifo: directed scenarios plus randomized traffic checked
// against a queue-based model of the TX/RX FIFOs and the CPU register port.
module tb_mesh_nic_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in, d_out, net_di, net_do;
  logic        nicEn, nicEnWR, net_si, net_ri, net_so, net_ro, net_polarity;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] tx_q[$];
  logic [63:0] rx_q[$];
  logic [63:0] exp_dout = '0;
  logic [63:0] rx_pkts[5];

  always #5 clk = ~clk;

  mesh_nic_fifo #(.PACKET_WIDTH(64), .DEPTH(DEPTH), .VC_BIT(63)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicEnWR(nicEnWR), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  function automatic logic exp_si();
    return (tx_q.size() != 0) && net_ri && (tx_q[0][63] == net_polarity);
  endfunction

  function automatic logic exp_ro();
    return rx_q.size() < DEPTH;
  endfunction

  // Applies one rising edge to the model using the inputs held across it.
  task automatic model_edge();
    logic si, ro, rx_ne, tx_full;
    if (!reset) begin
      tx_q.delete();
      rx_q.delete();
      exp_dout = '0;
      return;
    end
    si      = exp_si();
    ro      = exp_ro();
    rx_ne   = rx_q.size() != 0;
    tx_full = tx_q.size() == DEPTH;
    if (si) void'(tx_q.pop_front());
    if (nicEn && nicEnWR && addr == 2'b10 && !tx_full) tx_q.push_back(d_in);
    if (nicEn && !nicEnWR) begin
      case (addr)
        2'b00:   exp_dout = rx_ne ? rx_q.pop_front() : 64'd0;
        2'b01:   exp_dout = 64'(rx_ne);
        2'b10:   exp_dout = 64'd0;
        default: exp_dout = 64'(tx_full);
      endcase
    end
    if (net_so && ro) rx_q.push_back(net_do);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    nicEn = 0; nicEnWR = 0; addr = 2'b00; d_in = '0; net_so = 0; net_do = '0;
  endtask

  task automatic cpu_write(input logic [63:0] v);
    nicEn = 1; nicEnWR = 1; addr = 2'b10; d_in = v;
    cycle();
    idle();
  endtask

  task automatic cpu_read(input logic [1:0] a);
    nicEn = 1; nicEnWR = 0; addr = a;
    cycle();
    idle();
  endtask

  task automatic test_reset();
    idle();
    net_ri = 0; net_polarity = 0;
    reset = 1;
    #2 reset = 0;
    #1;
    n_checks++;
    if (d_out !== 64'd0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", d_out); end
    n_checks++;
    if (net_si !== 1'b0) begin n_fail++; $display("FAIL reset_si: got %b expected 0", net_si); end
    n_checks++;
    if (net_ro !== 1'b1) begin n_fail++; $display("FAIL reset_ro: got %b expected 1", net_ro); end
    cycle();
    cycle();
    reset = 1;
    cycle();
  endtask

  task automatic test_tx_inject();
    logic [63:0] pkt = 64'h8000_0000_0000_00A5;
    net_ri = 1; net_polarity = 1;
    cpu_write(pkt);
    #1;
    n_checks++;
    if (net_si !== 1'b1) begin n_fail++; $display("FAIL inject_si: got %b expected 1", net_si); end
    n_checks++;
    if (net_di !== pkt) begin n_fail++; $display("FAIL inject_di: got %h expected %h", net_di, pkt); end
    cycle();
    #1;
    n_checks++;
    if (net_si !== 1'b0) begin n_fail++; $display("FAIL inject_empty_si: got %b expected 0", net_si); end
    net_ri = 0;
    cpu_read(2'b11);
    n_checks++;
    if (d_out !== 64'd0) begin n_fail++; $display("FAIL inject_tx_status: got %h expected 0", d_out); end
  endtask

  task automatic test_polarity_hold();
    logic [63:0] pkt = 64'h0000_0000_1234_5678;
    net_ri = 1; net_polarity = 1;
    cpu_write(pkt);
    cycle();
    #1;
    n_checks++;
    if (net_si !== 1'b0) begin n_fail++; $display("FAIL pol_hold_si: got %b expected 0", net_si); end
    n_checks++;
    if (net_di !== pkt) begin n_fail++; $display("FAIL pol_hold_di: got %h expected %h", net_di, pkt); end
    net_polarity = 0;
    #1;
    n_checks++;
    if (net_si !== 1'b1) begin n_fail++; $display("FAIL pol_toggle_si: got %b expected 1", net_si); end
    cycle();
    #1;
    n_checks++;
    if (net_si !== 1'b0) begin n_fail++; $display("FAIL pol_after_pop_si: got %b expected 0", net_si); end
    net_ri = 0;
  endtask

  task automatic test_rx_full();
    net_ri = 0;
    for (int i = 0; i < 5; i++) begin
      rx_pkts[i] = {$urandom, $urandom};
      net_so = 1; net_do = rx_pkts[i];
      #1;
      n_checks++;
      if (net_ro !== (i < DEPTH)) begin
        n_fail++; $display("FAIL rx_full_ro[%0d]: got %b expected %b", i, net_ro, (i < DEPTH));
      end
      cycle();
    end
    idle();
    #1;
    n_checks++;
    if (net_ro !== 1'b0) begin n_fail++; $display("FAIL rx_full_ro_after: got %b expected 0", net_ro); end
    cpu_read(2'b01);
    n_checks++;
    if (d_out !== 64'd1) begin n_fail++; $display("FAIL rx_status: got %h expected 1", d_out); end
  endtask

  task automatic test_rx_drain();
    for (int i = 0; i < DEPTH; i++) begin
      cpu_read(2'b00);
      n_checks++;
      if (d_out !== rx_pkts[i]) begin
        n_fail++; $display("FAIL rx_drain[%0d]: got %h expected %h", i, d_out, rx_pkts[i]);
      end
    end
    cpu_read(2'b00);
    n_checks++;
    if (d_out !== 64'd0) begin n_fail++; $display("FAIL rx_drain_empty: got %h expected 0", d_out); end
    cpu_read(2'b01);
    n_checks++;
    if (d_out !== 64'd0) begin n_fail++; $display("FAIL rx_status_empty: got %h expected 0", d_out); end
  endtask

  task automatic test_tx_overflow();
    logic [63:0] pk[5];
    net_ri = 0; net_polarity = 1;
    for (int i = 0; i < 5; i++) begin
      pk[i] = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      cpu_write(pk[i]);
    end
    cpu_read(2'b11);
    n_checks++;
    if (d_out !== 64'd1) begin n_fail++; $display("FAIL tx_full_status: got %h expected 1", d_out); end
    net_ri = 1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_checks++;
      if (net_si !== 1'b1 || net_di !== pk[i]) begin
        n_fail++; $display("FAIL tx_drain[%0d]: got si=%b di=%h expected si=1 di=%h", i, net_si, net_di, pk[i]);
      end
      cycle();
    end
    #1;
    n_checks++;
    if (net_si !== 1'b0) begin n_fail++; $display("FAIL tx_overflow_dropped: got si=%b expected 0", net_si); end
    net_ri = 0;
  endtask

  task automatic test_reset_mid();
    net_ri = 0; net_polarity = 1;
    cpu_write(64'h8000_0000_0000_0001);
    cpu_write(64'h8000_0000_0000_0002);
    for (int i = 0; i < 3; i++) begin
      net_so = 1; net_do = {$urandom, $urandom};
      cycle();
    end
    idle();
    cpu_read(2'b01);
    n_checks++;
    if (d_out !== 64'd1) begin n_fail++; $display("FAIL mid_pre_status: got %h expected 1", d_out); end
    net_ri = 1;
    #1;
    n_checks++;
    if (net_si !== exp_si()) begin n_fail++; $display("FAIL mid_pre_si: got %b expected %b", net_si, exp_si()); end
    #1 reset = 0;
    tx_q.delete(); rx_q.delete(); exp_dout = '0;
    #1;
    n_checks++;
    if (net_si !== 1'b0 || net_ro !== 1'b1 || d_out !== 64'd0) begin
      n_fail++; $display("FAIL mid_reset: got si=%b ro=%b dout=%h expected si=0 ro=1 dout=0", net_si, net_ro, d_out);
    end
    net_ri = 0;
    cycle();
    reset = 1;
    cpu_read(2'b01);
    n_checks++;
    if (d_out !== 64'd0) begin n_fail++; $display("FAIL mid_rx_status: got %h expected 0", d_out); end
    cpu_read(2'b11);
    n_checks++;
    if (d_out !== 64'd0) begin n_fail++; $display("FAIL mid_tx_status: got %h expected 0", d_out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      nicEn        = ($urandom_range(0, 3) != 0);
      nicEnWR      = $urandom_range(0, 1);
      addr         = 2'($urandom_range(0, 3));
      d_in         = {$urandom, $urandom};
      net_so       = $urandom_range(0, 1);
      net_do       = {$urandom, $urandom};
      net_ri       = $urandom_range(0, 1);
      net_polarity = $urandom_range(0, 1);
      #1;
      n_checks++;
      if (net_si !== exp_si() || net_ro !== exp_ro()) begin
        n_fail++; $display("FAIL rand_flags[%0d]: got si=%b ro=%b expected si=%b ro=%b", i, net_si, net_ro, exp_si(), exp_ro());
      end
      if (tx_q.size() != 0) begin
        n_checks++;
        if (net_di !== tx_q[0]) begin
          n_fail++; $display("FAIL rand_di[%0d]: got %h expected %h", i, net_di, tx_q[0]);
        end
      end
      cycle();
      n_checks++;
      if (d_out !== exp_dout) begin
        n_fail++; $display("FAIL rand_dout[%0d]: got %h expected %h", i, d_out, exp_dout);
      end
    end
    idle();
    net_ri = 0;
  endtask

  initial begin
    test_reset();
    test_tx_inject();
    test_polarity_hold();
    test_rx_full();
    test_rx_drain();
    test_tx_overflow();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
